// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder -- bit-serial WIDTH-bit adder.
//
// Two operands are captured on an accepted start and summed one bit per clock,
// LSB first. The per-bit full adder is two half_adder cells plus an OR, and a
// carry flip-flop carries between bits. The result (sum + carry-out) is
// registered when the last bit is processed and a one-cycle done pulse marks it.
//
// Optional feature macro: SERIAL_ADDER_CIN_EN
//   defined   -> adds input cin, captured with a/b, seeds the carry FF
//   undefined -> no cin port, carry FF starts at 0
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, honoured only while ready=1
//   cin    in   carry-in (only with SERIAL_ADDER_CIN_EN)
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   ready  out  1 in IDLE
//   busy   out  1 while bits are being shifted
//   done   out  one-cycle pulse, sum/carry valid
//   sum    out  WIDTH-bit result, held until the next completion
//   carry  out  carry-out of the MSB, held with sum
// ---------------------------------------------------------------------------

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    // Wide enough to hold WIDTH so the count never wraps, even at WIDTH=1.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum_sr, w_sum_sr_next;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry, r_done, r_c;
    logic [CW-1:0]    r_cnt;
    logic             w_ha0_s, w_ha0_c, w_s, w_ha1_c, w_c_next;
    logic             w_last, w_cin;

`ifdef SERIAL_ADDER_CIN_EN
    assign w_cin = cin;
`else
    assign w_cin = 1'b0;
`endif

    // Full adder for the current bit: (a^b) then (+c), carries ORed.
    half_adder u_ha0 (.i_a(r_a_sr[0]), .i_b(r_b_sr[0]), .o_s(w_ha0_s), .o_c(w_ha0_c));
    half_adder u_ha1 (.i_a(w_ha0_s),   .i_b(r_c),       .o_s(w_s),     .o_c(w_ha1_c));
    assign w_c_next = w_ha0_c | w_ha1_c;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_sr_next = w_s;
        end else begin : g_wn
            assign w_sum_sr_next = {w_s, r_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:              w_next = S_IDLE;
            default:             w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ready = (r_state == S_IDLE);
        busy  = (r_state == S_SHIFT);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_SHIFT) && w_last;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_c      <= w_cin;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                    end
                end
                S_SHIFT: begin
                    r_c      <= w_c_next;
                    r_sum_sr <= w_sum_sr_next;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    // Result is exposed only here, never mid-add.
                    if (w_last) begin
                        r_sum   <= w_sum_sr_next;
                        r_carry <= w_c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done  = r_done;
    assign sum   = r_sum;
    assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: each accepted add pushes a + b + cin and
// the accept cycle; a negedge monitor pops on done and checks value, latency,
// pulse width and output stability.
module tb_serial_adder;
    localparam int W = 4;
`ifdef SERIAL_ADDER_CIN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b, sum;
    logic         ready, busy, done, carry;
`ifdef SERIAL_ADDER_CIN_EN
    logic         cin;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADDER_CIN_EN
        .cin(cin),
`endif
        .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
        .sum(sum), .carry(carry)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    logic [W:0] prev_res;
    logic       rst_q = 1'b1, done_q = 1'b0, ready_due = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready_due && !rst) chk("ready_after_done", {31'd0, ready}, 32'd1);
            ready_due = 1'b0;
            if (done) begin
                chk("done_one_cycle", {31'd0, done_q}, 32'd0);
                chk("done_ready_busy", {30'd0, ready, busy}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'({carry, sum}), 32'(e.res));
                    chk("latency", cyc - e.acc, W + 1);
                end
                ready_due = 1'b1;
            end else if (!rst && !rst_q) begin
                chk("sum_stable", 32'({carry, sum}), 32'(prev_res));
            end
            prev_res = {carry, sum};
            rst_q    = rst;
            done_q   = done;
        end
    end

    // One add: wait for ready, accept, scramble inputs, check busy span.
    // inject pulses a stray start (7,7) during SHIFT, which must be ignored.
    task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin, input bit inject);
        int   n = 0;
        logic c;
        c = CIN_EN ? icin : 1'b0;
        @(negedge clk);
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
            return;
        end
        a = ia;
        b = ib;
`ifdef SERIAL_ADDER_CIN_EN
        cin = c;
`endif
        start = 1'b1;
        sb.push_back('{res: (W+1)'(ia) + (W+1)'(ib) + (W+1)'(c), acc: cyc});
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < W; i++) begin
            chk("busy_span", {30'd0, ready, busy}, 32'd1);
            if (inject && i == 1) begin
                start = 1'b1;
                a = W'(7);
                b = W'(7);
            end else begin
                start = 1'b0;
            end
            if (i < W - 1) @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_ADDER_CIN_EN
        cin = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_carry", {31'd0, carry}, 32'd0);
        chk("reset_ctrl", {29'd0, ready, busy, done}, 32'b100);
        rst = 1'b0;

        // Directed cases
        do_add(4'b0011, 4'b0101, 1'b0, 1'b0);
        do_add(4'hF, 4'h1, 1'b0, 1'b0);
        do_add(4'hF, 4'hF, 1'b0, 1'b0);
        do_add(4'h2, 4'h3, 1'b0, 1'b1);

        // Reset during SHIFT: no result must ever appear.
        @(negedge clk);
        while (!ready) @(negedge clk);
        a = 4'h9;
        b = 4'h9;
        start = 1'b1;
        @(negedge clk);           // after accept edge
        start = 1'b0;
        @(negedge clk);           // after first SHIFT edge
        rst = 1'b1;               // sampled at second SHIFT edge
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sum", 32'({carry, sum}), 32'd0);
        chk("abort_ctrl", {29'd0, ready, busy, done}, 32'b100);
        repeat (W + 3) @(negedge clk);
        do_add(4'h1, 4'h1, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_CIN_EN
        do_add(4'h0, 4'h0, 1'b1, 1'b0);
        do_add(4'hF, 4'h0, 1'b1, 1'b0);
`endif

        // Random traffic, variable gaps (gap 0 gives back-to-back accepts).
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
